// File: rtl/count_updown.sv
// rtl/count_updown.sv - prescaled up/down digit counter with load, wrap/saturate and cascade carry
// The prescaler makes a one-clock TICK every SEC1_MAX running clocks; each TICK advances COUNT.
module count_updown #(
   parameter int SEC1_MAX  = 50_000_000,
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 9,
   parameter int WRAP      = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             RUN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] COUNT,
   output logic             TICK,
   output logic             CARRY
);

   localparam int               PS_W    = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(SEC1_MAX - 1);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);

   logic [PS_W-1:0]  ps;
   logic [WIDTH-1:0] terminal;
   logic [WIDTH-1:0] load_clamped;
   logic             at_term;

   // With SEC1_MAX=1 ps is pinned at 0 == PS_LAST, so TICK follows RUN even in reset.
   assign TICK         = RUN && (ps == PS_LAST);
   assign terminal     = UP ? MAX_V : '0;
   assign at_term      = (COUNT == terminal);
   assign CARRY        = TICK && at_term;
   assign load_clamped = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ps <= '0;
      end else if (LOAD) begin
         ps <= '0;
      end else if (RUN) begin
         ps <= TICK ? '0 : ps + PS_W'(1);
      end
   end

   // LOAD outranks a coincident TICK; saturate mode simply holds at the terminal value.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         COUNT <= '0;
      end else if (LOAD) begin
         COUNT <= load_clamped;
      end else if (TICK) begin
         if (!at_term) begin
            COUNT <= UP ? COUNT + WIDTH'(1) : COUNT - WIDTH'(1);
         end else if (WRAP != 0) begin
            COUNT <= UP ? '0 : MAX_V;
         end
      end
   end

endmodule

// File: tb/tb_count_updown.sv
// tb/tb_count_updown.sv - directed bench for count_updown: wrap, saturate, load, pause, reset, cascade
module tb_count_updown;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run, up, load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tick, carry;

   logic       run_s, up_s, load_s;
   logic [3:0] load_val_s;
   logic [3:0] count_s;
   logic       tick_s, carry_s;

   logic       run_c;
   logic [3:0] count_u, count_t;
   logic       tick_u, carry_u, tick_t, carry_t;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   count_updown #(.SEC1_MAX(4), .WIDTH(4), .MAX_COUNT(9), .WRAP(1)) u (
      .CLK(clk), .RESET(rst_n), .RUN(run), .UP(up), .LOAD(load), .LOAD_VAL(load_val),
      .COUNT(count), .TICK(tick), .CARRY(carry));

   count_updown #(.SEC1_MAX(4), .WIDTH(4), .MAX_COUNT(9), .WRAP(0)) s (
      .CLK(clk), .RESET(rst_n), .RUN(run_s), .UP(up_s), .LOAD(load_s), .LOAD_VAL(load_val_s),
      .COUNT(count_s), .TICK(tick_s), .CARRY(carry_s));

   count_updown #(.SEC1_MAX(4), .WIDTH(4), .MAX_COUNT(9), .WRAP(1)) cu (
      .CLK(clk), .RESET(rst_n), .RUN(run_c), .UP(1'b1), .LOAD(1'b0), .LOAD_VAL(4'd0),
      .COUNT(count_u), .TICK(tick_u), .CARRY(carry_u));

   count_updown #(.SEC1_MAX(1), .WIDTH(4), .MAX_COUNT(5), .WRAP(1)) ct (
      .CLK(clk), .RESET(rst_n), .RUN(carry_u), .UP(1'b1), .LOAD(1'b0), .LOAD_VAL(4'd0),
      .COUNT(count_t), .TICK(tick_t), .CARRY(carry_t));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
      run_s = 1'b0; up_s = 1'b1; load_s = 1'b0; load_val_s = 4'd0;
      run_c = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_ps", u.ps, 0);
      chk("rst_tick", tick, 0);
      chk("rst_carry", carry, 0);

      // count up 44 cycles from release: value k/4 mod 10, tick when ps==3
      rst_n = 1'b1; run = 1'b1; up = 1'b1;
      for (int i = 1; i <= 44; i++) begin
         @(negedge clk);
         chk("up_count", count, (i / 4) % 10);
         chk("up_tick", tick, (i % 4) == 3);
         chk("up_carry", carry, ((i % 4) == 3) && (((i / 4) % 10) == 9));
      end
      chk("up_end_count", count, 1);

      // count down from 0: wraps to 9 with carry, then 8, 7
      load = 1'b1; load_val = 4'd0;
      @(negedge clk);
      load = 1'b0; up = 1'b0;
      chk("dn_load0", count, 0);
      chk("dn_ps0", u.ps, 0);
      repeat (3) @(negedge clk);
      chk("dn_tick", tick, 1);
      chk("dn_carry", carry, 1);
      @(negedge clk);
      chk("dn_wrap9", count, 9);
      chk("dn_carry_off", carry, 0);
      repeat (3) @(negedge clk);
      chk("dn_tick9", tick, 1);
      chk("dn_nocarry9", carry, 0);
      @(negedge clk);
      chk("dn_8", count, 8);
      repeat (4) @(negedge clk);
      chk("dn_7", count, 7);

      // load 12 on a tick edge: clamped to 9, prescaler restarts
      repeat (3) @(negedge clk);
      chk("ld_tick_pre", tick, 1);
      load = 1'b1; load_val = 4'd12; up = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("ld_clamp", count, 9);
      chk("ld_ps", u.ps, 0);
      chk("ld_tick_off", tick, 0);
      repeat (2) @(negedge clk);
      chk("ld_no_early_tick", tick, 0);
      @(negedge clk);
      chk("ld_tick4", tick, 1);
      chk("ld_carry", carry, 1);
      @(negedge clk);
      chk("ld_wrap0", count, 0);

      // pause at ps=2 for 10 cycles
      repeat (2) @(negedge clk);
      chk("pause_ps_pre", u.ps, 2);
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("pause_ps", u.ps, 2);
         chk("pause_count", count, 0);
         chk("pause_tick", tick, 0);
      end
      run = 1'b1;
      chk("resume_tick1", tick, 0);
      @(negedge clk);
      chk("resume_tick2", tick, 1);
      @(negedge clk);
      chk("resume_count", count, 1);

      // asynchronous reset between edges at count 5
      repeat (16) @(negedge clk);
      chk("pre_rst_count", count, 5);
      #5 rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_ps", u.ps, 0);
      chk("async_rst_tick", tick, 0);
      @(negedge clk);
      chk("rst_hold_count", count, 0);
      rst_n = 1'b1; run = 1'b0;

      // saturate mode: holds at 9 up, 0 down, carry every tick at terminal
      run_s = 1'b1; up_s = 1'b1; load_s = 1'b1; load_val_s = 4'd8;
      @(negedge clk);
      load_s = 1'b0;
      chk("sat_load8", count_s, 8);
      repeat (3) @(negedge clk);
      chk("sat_tick8", tick_s, 1);
      chk("sat_nocarry8", carry_s, 0);
      @(negedge clk);
      chk("sat_9", count_s, 9);
      for (int k = 0; k < 2; k++) begin
         repeat (3) @(negedge clk);
         chk("sat_up_carry", carry_s, 1);
         @(negedge clk);
         chk("sat_up_hold", count_s, 9);
      end
      up_s = 1'b0; load_s = 1'b1; load_val_s = 4'd0;
      @(negedge clk);
      load_s = 1'b0;
      repeat (3) @(negedge clk);
      chk("sat_dn_carry", carry_s, 1);
      @(negedge clk);
      chk("sat_dn_hold", count_s, 0);
      run_s = 1'b0;

      // cascade: tens stage (mod 6) advances once per 10 units ticks
      chk("chain_rst_u", count_u, 0);
      chk("chain_rst_t", count_t, 0);
      run_c = 1'b1;
      for (int i = 1; i <= 250; i++) begin
         @(negedge clk);
         chk("chain_units", count_u, (i / 4) % 10);
         chk("chain_tens", count_t, ((i / 4) / 10) % 6);
         if (i == 239) chk("chain_tens5", count_t, 5);
         if (i == 240) chk("chain_tens_wrap", count_t, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/count_updown.md
# count_updown

Parametrised successor to the 4-bit one-second counter used on the board designs. It keeps the same structure: an internal prescaler produces a one-clock enable every SEC1_MAX clocks, and that enable advances a counter. It adds configurable width and modulus, up/down direction, run/pause, synchronous load, wrap or saturate mode, and a carry output for cascading digits (seconds → tens of seconds → minutes).

## Interface
- SEC1_MAX, default 50_000_000: prescaler period in clocks; legal range ≥1. Benches override it with a small value (4).
- WIDTH, default 4: counter width in bits.
- MAX_COUNT, default 9: terminal value; the count range is 0..MAX_COUNT. Legal range 1..2^WIDTH-1.
- WRAP, default 1: 1 = wrap at terminal, 0 = saturate at terminal.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- RUN  input  1  1 = prescaler and counter advance; 0 = pause, all state held.
- UP  input  1  1 = count up, 0 = count down; sampled on each tick.
- LOAD  input  1  synchronous load strobe.
- LOAD_VAL  input  WIDTH  value for LOAD.
- COUNT  output  WIDTH  current count, registered.
- TICK  output  1  prescaler enable; combinational, high one cycle per period.
- CARRY  output  1  terminal-crossing pulse; combinational, drives the next stage's RUN.

## Operation
- Prescaler PS:
  - Width is max(1, $clog2(SEC1_MAX)); range 0..SEC1_MAX-1.
  - TICK = RUN && (PS == SEC1_MAX-1).
  - On an edge with RUN=1: PS becomes 0 if TICK, else PS+1.
  - RUN=0 holds PS.
  - With SEC1_MAX=1, TICK = RUN.
- Terminal value: T = MAX_COUNT when UP=1, T = 0 when UP=0.
- CARRY = TICK && (COUNT == T). It is combinational and is never registered inside the block.
- Counter update priority per rising edge, highest first:
  1. LOAD=1: COUNT ← min(LOAD_VAL, MAX_COUNT); PS ← 0. This applies regardless of RUN, and LOAD overrides a coincident TICK.
  2. TICK=1 and COUNT≠T:
     - UP=1: COUNT ← COUNT+1.
     - UP=0: COUNT ← COUNT−1.
  3. TICK=1 and COUNT==T:
     - WRAP=1 and UP=1: COUNT ← 0.
     - WRAP=1 and UP=0: COUNT ← MAX_COUNT.
     - WRAP=0: COUNT holds; CARRY still pulses once per tick spent at terminal.
  4. Otherwise COUNT holds.
- All arithmetic is WIDTH bits. For MAX_COUNT = 2^WIDTH-1, wrap falls out of modular arithmetic and must still match rule 3.
- Changing UP takes effect at the next tick with no glitch on COUNT.
- A COUNT value above MAX_COUNT is unreachable: reset gives 0 and LOAD is clamped.

## Timing
- Reset (RESET=0, asynchronous): COUNT=0 and PS=0 immediately.
  - TICK=0 and CARRY=0 while in reset, except TICK = RUN when SEC1_MAX=1.
  - Release is synchronous to use; the first PS increment occurs on the first rising edge with RESET=1 and RUN=1.
- Tick latency: with RUN held high from reset release, TICK is high during the SEC1_MAX-th cycle. COUNT changes on the edge that ends that cycle, then repeats every SEC1_MAX cycles.
- CARRY is coincident with the TICK cycle in which COUNT==T. The downstream stage sees its enable in the same cycle and updates on the same edge as the wrapping stage.
- LOAD latency: COUNT shows the loaded value one edge after LOAD is sampled. The next tick then comes SEC1_MAX cycles after the load edge.
- RUN deasserted mid-period: PS freezes. On re-enable the period resumes, so total running cycles per tick stay SEC1_MAX.
- Reset asserted mid-period or mid-load: everything returns to reset values immediately; no partial state survives.

## Test plan
- Test parameters: SEC1_MAX=4, WIDTH=4, MAX_COUNT=9, WRAP=1, CYCLE=20 ns.
- Reset then RUN=1, UP=1 for 44 cycles → COUNT steps 0,1,…,9,0 every 4 clocks. CARRY is high exactly in the cycle where COUNT=9 and TICK=1, and nowhere else.
- UP=0 from COUNT=0 → the next tick gives COUNT=9 with CARRY high in that tick cycle; the following ticks give 8, 7.
- LOAD=1 with LOAD_VAL=12 coincident with TICK → COUNT=9 (clamped), no increment, PS=0, and the next tick arrives 4 cycles later.
- WRAP=0, UP=1, run to 9 → COUNT holds at 9 and CARRY pulses on every subsequent tick. With UP=0 at 0 → COUNT holds at 0.
- RUN=0 for 10 cycles at PS=2 → COUNT and PS frozen and TICK=0; after RUN=1 the tick comes 2 cycles later.
- RESET=0 pulsed asynchronously between clock edges at COUNT=5 → COUNT=0 before the next edge. Also chain two instances (tens stage RUN = units CARRY, MAX_COUNT=5) → the tens digit increments once per 10 units ticks and wraps 5→0.
